// File: rtl/vga_sync.sv
// 640x480@60 Hz VGA timing generator: pixel-rate enable, h/v counters,
// registered sync pulses aligned with the counters, display-area and frame flags.
module vga_sync #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_RETRACE = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_RETRACE = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       p_tick,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_tick
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_RETRACE + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_RETRACE + V_BACK;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS     = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS     = 10'(V_DISPLAY);
  localparam logic [9:0] H_SYNC_LO = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] H_SYNC_HI = 10'(H_DISPLAY + H_FRONT + H_RETRACE - 1);
  localparam logic [9:0] V_SYNC_LO = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] V_SYNC_HI = 10'(V_DISPLAY + V_FRONT + V_RETRACE - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic [9:0]       r_pix_x;
  logic [9:0]       r_pix_y;
  logic             r_hsync;
  logic             r_vsync;

  logic             w_tick;
  logic             w_h_end;
  logic             w_v_end;
  logic [9:0]       w_x_next;
  logic [9:0]       w_y_next;
  logic             w_hs_act;
  logic             w_vs_act;

  // Tick is masked by reset so that CLK_DIV = 1 still shows no tick while held.
  always_comb begin
    w_tick   = (r_div_cnt == DIV_LAST) && !reset;
    w_h_end  = (r_pix_x == H_LAST);
    w_v_end  = (r_pix_y == V_LAST);
    w_x_next = r_pix_x;
    w_y_next = r_pix_y;
    if (w_tick) begin
      w_x_next = w_h_end ? '0 : r_pix_x + 10'd1;
      if (w_h_end) begin
        w_y_next = w_v_end ? '0 : r_pix_y + 10'd1;
      end
    end
    w_hs_act = (w_x_next >= H_SYNC_LO) && (w_x_next <= H_SYNC_HI);
    w_vs_act = (w_y_next >= V_SYNC_LO) && (w_y_next <= V_SYNC_HI);
  end

  // Syncs are decoded from next-state counters so they switch on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_pix_x   <= '0;
      r_pix_y   <= '0;
      r_hsync   <= ~SYNC_POL;
      r_vsync   <= ~SYNC_POL;
    end else begin
      r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + DIV_W'(1);
      r_pix_x   <= w_x_next;
      r_pix_y   <= w_y_next;
      r_hsync   <= w_hs_act ? SYNC_POL : ~SYNC_POL;
      r_vsync   <= w_vs_act ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign p_tick     = w_tick;
  assign pix_x      = r_pix_x;
  assign pix_y      = r_pix_y;
  assign video_on   = (r_pix_x < H_VIS) && (r_pix_y < V_VIS);
  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign frame_tick = w_tick && w_h_end && w_v_end;

endmodule

// File: tb/tb_vga_sync.sv
// Scoreboard bench for vga_sync: four builds (default, CLK_DIV=4, small geometry,
// small geometry active-high syncs) checked every cycle against a closed-form timing model.
module tb_vga_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  logic       pt_m, von_m, hs_m, vs_m, ft_m;
  logic [9:0] x_m, y_m;
  logic       pt_q, von_q, hs_q, vs_q, ft_q;
  logic [9:0] x_q, y_q;
  logic       pt_s, von_s, hs_s, vs_s, ft_s;
  logic [9:0] x_s, y_s;
  logic       pt_p, von_p, hs_p, vs_p, ft_p;
  logic [9:0] x_p, y_p;

  vga_sync #(.CLK_DIV(2)) u_main (
    .clk(clk), .reset(rst), .p_tick(pt_m), .pix_x(x_m), .pix_y(y_m),
    .video_on(von_m), .hsync(hs_m), .vsync(vs_m), .frame_tick(ft_m));

  vga_sync #(.CLK_DIV(4)) u_div4 (
    .clk(clk), .reset(rst), .p_tick(pt_q), .pix_x(x_q), .pix_y(y_q),
    .video_on(von_q), .hsync(hs_q), .vsync(vs_q), .frame_tick(ft_q));

  vga_sync #(.CLK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_RETRACE(3), .H_BACK(3),
             .V_DISPLAY(6), .V_FRONT(1), .V_RETRACE(2), .V_BACK(1), .SYNC_POL(1'b0)) u_small (
    .clk(clk), .reset(rst), .p_tick(pt_s), .pix_x(x_s), .pix_y(y_s),
    .video_on(von_s), .hsync(hs_s), .vsync(vs_s), .frame_tick(ft_s));

  vga_sync #(.CLK_DIV(1), .H_DISPLAY(8), .H_FRONT(2), .H_RETRACE(3), .H_BACK(3),
             .V_DISPLAY(6), .V_FRONT(1), .V_RETRACE(2), .V_BACK(1), .SYNC_POL(1'b1)) u_pol (
    .clk(clk), .reset(rst), .p_tick(pt_p), .pix_x(x_p), .pix_y(y_p),
    .video_on(von_p), .hsync(hs_p), .vsync(vs_p), .frame_tick(ft_p));

  typedef struct packed {
    logic       pt;
    logic [9:0] x;
    logic [9:0] y;
    logic       von;
    logic       hs;
    logic       vs;
    logic       ft;
  } smp_t;

  typedef struct {
    int   id;
    bit   dir;
    int   n;
    smp_t e;
  } rec_t;

  typedef struct {
    int   id;
    bit   rst;
    int   n;
    smp_t e;
  } dvec_t;

  rec_t  sb[$];
  dvec_t dv[$];
  int    ft_pos[$];

  int tests = 0;
  int fails = 0;
  int n = 0;
  bit nvalid = 1'b0;
  bit win = 1'b0;

  // Closed-form timing: n clk edges after reset -> pixel n/d of a raster scan.
  function automatic smp_t model(int cyc, bit r, int d, int hd, int hf, int hr, int hb,
                                 int vd, int vf, int vr, int vb, bit pol);
    smp_t s;
    int ht = hd + hf + hr + hb;
    int vt = vd + vf + vr + vb;
    int pc = cyc / d;
    int x  = pc % ht;
    int y  = (pc / ht) % vt;
    s.pt  = !r && ((cyc % d) == d - 1);
    s.x   = 10'(x);
    s.y   = 10'(y);
    s.von = (x < hd) && (y < vd);
    s.hs  = (x >= hd + hf && x < hd + hf + hr) ? pol : !pol;
    s.vs  = (y >= vd + vf && y < vd + vf + vr) ? pol : !pol;
    s.ft  = s.pt && (x == ht - 1) && (y == vt - 1);
    return s;
  endfunction

  function automatic smp_t model_id(int id, int cyc, bit r);
    case (id)
      0:       return model(cyc, r, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
      1:       return model(cyc, r, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
      2:       return model(cyc, r, 2, 8, 2, 3, 3, 6, 1, 2, 1, 1'b0);
      default: return model(cyc, r, 1, 8, 2, 3, 3, 6, 1, 2, 1, 1'b1);
    endcase
  endfunction

  function automatic smp_t actual(int id);
    case (id)
      0:       return '{pt_m, x_m, y_m, von_m, hs_m, vs_m, ft_m};
      1:       return '{pt_q, x_q, y_q, von_q, hs_q, vs_q, ft_q};
      2:       return '{pt_s, x_s, y_s, von_s, hs_s, vs_s, ft_s};
      default: return '{pt_p, x_p, y_p, von_p, hs_p, vs_p, ft_p};
    endcase
  endfunction

  task automatic add_dv(int id, bit r, int cyc, bit pt, int x, int y,
                        bit von, bit hs, bit vs, bit ft);
    dvec_t d;
    d.id = id; d.rst = r; d.n = cyc;
    d.e = '{pt, 10'(x), 10'(y), von, hs, vs, ft};
    dv.push_back(d);
  endtask

  task automatic check(string name, int got, int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // One clk edge: advance the bench time base, set reset for the next edge,
  // and queue the expected output sample for every build.
  task automatic step(bit next_rst);
    rec_t r;
    @(posedge clk);
    if (rst) begin
      n = 0;
      nvalid = 1'b1;
    end else if (nvalid) begin
      n++;
    end
    #1 rst = next_rst;
    if (nvalid) begin
      for (int id = 0; id < 4; id++) begin
        r.id = id; r.dir = 1'b0; r.n = n; r.e = model_id(id, n, rst);
        sb.push_back(r);
      end
      foreach (dv[k]) begin
        if (dv[k].rst == rst && dv[k].n == n) begin
          r.id = dv[k].id; r.dir = 1'b1; r.n = n; r.e = dv[k].e;
          sb.push_back(r);
        end
      end
    end
  endtask

  // Monitor: compare every queued expectation against the DUT mid-cycle.
  initial begin
    rec_t r;
    smp_t a;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        r = sb.pop_front();
        a = actual(r.id);
        tests++;
        if (a !== r.e) begin
          fails++;
          $display("FAIL %s id=%0d n=%0d got pt=%0b x=%0d y=%0d von=%0b hs=%0b vs=%0b ft=%0b want pt=%0b x=%0d y=%0d von=%0b hs=%0b vs=%0b ft=%0b",
                   r.dir ? "directed" : "timing", r.id, r.n,
                   a.pt, a.x, a.y, a.von, a.hs, a.vs, a.ft,
                   r.e.pt, r.e.x, r.e.y, r.e.von, r.e.hs, r.e.vs, r.e.ft);
        end
      end
      if (win && n < 640 && ft_s === 1'b1) ft_pos.push_back(n);
    end
  end

  initial begin
    // default build, CLK_DIV=2: reset values, first tick, line 0 edges, line wrap
    add_dv(0, 1'b1,    0, 1'b0,   0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    add_dv(0, 1'b0,    1, 1'b1,   0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    add_dv(0, 1'b0,    2, 1'b0,   1, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    add_dv(0, 1'b0, 1280, 1'b0, 640, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    add_dv(0, 1'b0, 1311, 1'b1, 655, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    add_dv(0, 1'b0, 1312, 1'b0, 656, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    add_dv(0, 1'b0, 1503, 1'b1, 751, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    add_dv(0, 1'b0, 1504, 1'b0, 752, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    add_dv(0, 1'b0, 1599, 1'b1, 799, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    add_dv(0, 1'b0, 1600, 1'b0,   0, 1, 1'b1, 1'b1, 1'b1, 1'b0);
    // CLK_DIV=4: one tick per four clks
    add_dv(1, 1'b0,    3, 1'b1,   0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    add_dv(1, 1'b0,    4, 1'b0,   1, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    add_dv(1, 1'b0, 2624, 1'b0, 656, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    // small 16x10 raster, CLK_DIV=2: vsync lines 7..8, blanking, frame wrap
    add_dv(2, 1'b0,   20, 1'b0,  10, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    add_dv(2, 1'b0,  192, 1'b0,   0, 6, 1'b0, 1'b1, 1'b1, 1'b0);
    add_dv(2, 1'b0,  223, 1'b1,  15, 6, 1'b0, 1'b1, 1'b1, 1'b0);
    add_dv(2, 1'b0,  224, 1'b0,   0, 7, 1'b0, 1'b1, 1'b0, 1'b0);
    add_dv(2, 1'b0,  288, 1'b0,   0, 9, 1'b0, 1'b1, 1'b1, 1'b0);
    add_dv(2, 1'b0,  319, 1'b1,  15, 9, 1'b0, 1'b1, 1'b1, 1'b1);
    add_dv(2, 1'b0,  320, 1'b0,   0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    // small raster, active-high syncs, CLK_DIV=1
    add_dv(3, 1'b1,    0, 1'b0,   0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    add_dv(3, 1'b0,   10, 1'b1,  10, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    add_dv(3, 1'b0,   13, 1'b1,  13, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_dv(3, 1'b0,  112, 1'b1,   0, 7, 1'b0, 1'b0, 1'b1, 1'b0);
    add_dv(3, 1'b0,  159, 1'b1,  15, 9, 1'b0, 1'b0, 1'b0, 1'b1);

    // power-on reset for three edges, then count into line 0
    step(1'b1);
    step(1'b1);
    step(1'b0);
    for (int i = 0; i < 700; i++) step(1'b0);
    // mid-count reset held for five edges
    step(1'b1);
    for (int i = 0; i < 4; i++) step(1'b1);
    step(1'b0);
    win = 1'b1;
    for (int i = 0; i < 3400; i++) step(1'b0);
    win = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;

    check("scoreboard_drained", sb.size(), 0);
    check("frame_tick_count", ft_pos.size(), 2);
    if (ft_pos.size() == 2) begin
      check("frame_tick_first", ft_pos[0], 319);
      check("frame_tick_spacing", ft_pos[1] - ft_pos[0], 320);
    end else begin
      check("frame_tick_positions", ft_pos.size(), 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
